btn_press_encoder: RTL and testbench
====================================

Name: btn_press_encoder

Overview:
- Producer side of the game's button-input path: turns the three raw board keys into clean, encoded, acknowledged press events for the Genius FSM.
- Synchronizes and debounces the keys, detects one press per physical push, and encodes which key was pressed.
- Holds each event in a one-entry buffer until the consumer acknowledges it, and flags lost events.

Parameters:
- DEBOUNCE_CYCLES, 500000, clock cycles an input must stay stable to be accepted (10 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 20, width of the debounce counter.
- BTN_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (board KEYs); 0 = active-high.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- btn_raw  in  3  asynchronous raw keys, polarity set by BTN_ACTIVE_LOW.
- press_ack  in  1  consumer accepts the current event; meaningful only while press_valid=1.
- press_valid  out  1  an event is pending; held until acknowledged.
- press_code  out  2  00/01/10 = key 0/1/2; 11 = more than one key pressed together.
- press_overflow  out  1  sticky; an event was dropped because the buffer was full.
- busy  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset: reset is synchronous, active-low; clock is clock. reset=0 at a rising edge gives:
  - state=IDLE, counter=0;
  - both synchronizer stages loaded with the released level;
  - press_valid=0, press_code=00, press_overflow=0, busy=0.
  - Reset mid-debounce or with an event pending discards everything, with no event emitted.
- Input conditioning:
  - 2-flop synchronizer per bit.
  - pressed[2:0] = synchronized value, inverted when BTN_ACTIVE_LOW=1.
- FSM, 4 states:
  - IDLE: if pressed != 000, snapshot <= pressed, cnt <= 0, go DB_PRESS.
  - DB_PRESS:
    - If pressed == 000, go IDLE.
    - Else if pressed != snapshot, snapshot <= pressed and cnt <= 0; stay.
    - Else if cnt == DEBOUNCE_CYCLES-1, emit event from snapshot and go HELD.
    - Else cnt+1.
  - HELD: wait for pressed == 000, then cnt <= 0 and go DB_RELEASE. Extra keys added while held are ignored; no new event.
  - DB_RELEASE:
    - If pressed != 000, go HELD.
    - Else if cnt == DEBOUNCE_CYCLES-1, go IDLE.
    - Else cnt+1.
- Encoding from snapshot:
  - exactly one bit set gives that bit's index;
  - two or more bits set gives 11.
- Event buffer (one entry):
  - On emit, if press_valid=0 or press_ack=1 in the same cycle: load press_code and set press_valid=1. A simultaneous ack plus emit leaves press_valid=1 with the new code.
  - On emit with press_valid=1 and press_ack=0: event dropped, press_code unchanged, press_overflow <= 1.
  - press_ack=1 with no emit clears press_valid next edge; press_code keeps its last value.
  - press_ack while press_valid=0 is ignored.
  - press_overflow clears only on reset.
- Latency: counting the edge that first samples a stable press as edge 1, press_valid rises after edge DEBOUNCE_CYCLES+3.
- Counter never wraps: it saturates by the state transition at DEBOUNCE_CYCLES-1.
- busy = (state != IDLE), registered with the state.

Test Plan:
(DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1)
- Reset: hold reset=0 for 3 cycles with btn_raw=111 -> all outputs 0. Release reset -> press_valid stays 0 and busy=0.
- Clean single press: btn_raw=110 held 20 cycles, press_ack=0 -> press_valid=1 and press_code=00 after edge 7. Only one event is produced. After release plus 4 stable cycles, busy=0.
- Bounce: btn_raw toggles 101/111 every 2 cycles for 10 cycles, then 101 stable -> exactly one event with code 01, valid 7 edges after the stable level starts. No event during the bounce.
- Multi-key and handshake: btn_raw=010 stable -> press_code=11. Pulse press_ack for 1 cycle -> press_valid=0 next edge.
- Overflow: two separate clean presses (011 then 110) with press_ack=0 -> press_code stays 10, press_overflow=1. A later ack clears valid but press_overflow stays 1.
- Ack/emit collision and mid-operation reset:
  - Assert press_ack on the exact emit cycle of a second press -> press_valid stays 1 with the new code, no overflow.
  - Assert reset=0 during DB_PRESS -> no event appears, state returns to IDLE.

Source files
------------

// File: rtl/btn_press_encoder_if.sv
// rtl/btn_press_encoder_if.sv - press-event handshake bundle between the key encoder and its consumer
//
// Signals:
//   press_valid    event pending, held until acknowledged        (producer -> consumer)
//   press_code     2-bit key code of the pending/last event      (producer -> consumer)
//   press_overflow sticky flag: an event was lost, buffer full    (producer -> consumer)
//   busy           producer FSM is not idle                       (producer -> consumer)
//   press_ack      consumer accepts the pending event             (consumer -> producer)
//
// Modports:
//   master - the encoder (event producer)
//   slave  - the game FSM (event consumer)

interface btn_press_encoder_if;
    logic       press_valid;
    logic [1:0] press_code;
    logic       press_overflow;
    logic       busy;
    logic       press_ack;

    modport master (
        output press_valid,
        output press_code,
        output press_overflow,
        output busy,
        input  press_ack
    );

    modport slave (
        input  press_valid,
        input  press_code,
        input  press_overflow,
        input  busy,
        output press_ack
    );
endinterface

// File: rtl/btn_press_encoder.sv
// rtl/btn_press_encoder.sv - debounced, encoded, acknowledged press events from three raw board keys
//
// Ports:
//   clock    in   system clock, all logic on the rising edge
//   reset    in   synchronous, active-low reset
//   btn_raw  in   3 asynchronous raw keys, polarity set by BTN_ACTIVE_LOW
//   evt      master side of btn_press_encoder_if:
//              press_valid / press_code / press_overflow / busy out, press_ack in
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles an input must stay stable to be accepted (2 .. 2^CNT_W-1)
//   CNT_W            debounce counter width
//   BTN_ACTIVE_LOW   1: a key reads 0 when pressed; 0: active-high keys

module btn_press_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2:0]           btn_raw,
    btn_press_encoder_if.master  evt
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    // Level the raw keys show when nothing is pressed; the synchronizer
    // resets to it so a reset never looks like a press.
    localparam logic [2:0]       RELEASED = (BTN_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [2:0] sync_meta;
    logic [2:0] sync_stable;
    logic [2:0] pressed;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_meta   <= RELEASED;
            sync_stable <= RELEASED;
        end else begin
            sync_meta   <= btn_raw;
            sync_stable <= sync_meta;
        end
    end

    assign pressed = (BTN_ACTIVE_LOW != 0) ? ~sync_stable : sync_stable;

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       snapshot;
    logic [2:0]       snapshot_nxt;
    logic             busy_q;
    logic             emit;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            snapshot <= 3'b000;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            snapshot <= snapshot_nxt;
            // Registered alongside the state so busy never glitches.
            busy_q   <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        snapshot_nxt = snapshot;
        emit         = 1'b0;

        case (state)
            IDLE: begin
                if (pressed != 3'b000) begin
                    snapshot_nxt = pressed;
                    cnt_nxt      = '0;
                    state_nxt    = DB_PRESS;
                end
            end

            DB_PRESS: begin
                if (pressed == 3'b000) begin
                    state_nxt = IDLE;
                end else if (pressed != snapshot) begin
                    // Key set still settling: restart the stability window
                    // on the new combination.
                    snapshot_nxt = pressed;
                    cnt_nxt      = '0;
                end else if (cnt == CNT_LAST) begin
                    emit      = 1'b1;
                    state_nxt = HELD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            HELD: begin
                // Keys added while held are deliberately ignored: one
                // physical push yields exactly one event.
                if (pressed == 3'b000) begin
                    cnt_nxt   = '0;
                    state_nxt = DB_RELEASE;
                end
            end

            DB_RELEASE: begin
                if (pressed != 3'b000) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Key encoding: a single key gives its index, any chord gives 11
    // ------------------------------------------------------------------
    logic [1:0] emit_code;

    always_comb begin
        emit_code = 2'b11;
        case (snapshot)
            3'b001:  emit_code = 2'b00;
            3'b010:  emit_code = 2'b01;
            3'b100:  emit_code = 2'b10;
            default: emit_code = 2'b11;
        endcase
    end

    // ------------------------------------------------------------------
    // One-entry event buffer
    // ------------------------------------------------------------------
    logic       valid_q;
    logic [1:0] code_q;
    logic       overflow_q;
    logic       slot_free;

    // An ack arriving on the emit cycle frees the slot in time for the
    // new event, so the collision case never counts as an overflow.
    assign slot_free = !valid_q || evt.press_ack;

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            code_q     <= 2'b00;
            overflow_q <= 1'b0;
        end else if (emit) begin
            if (slot_free) begin
                valid_q <= 1'b1;
                code_q  <= emit_code;
            end else begin
                overflow_q <= 1'b1;
            end
        end else if (evt.press_ack) begin
            // Code is kept so the consumer can still read the last key.
            valid_q <= 1'b0;
        end
    end

    assign evt.press_valid    = valid_q;
    assign evt.press_code     = code_q;
    assign evt.press_overflow = overflow_q;
    assign evt.busy           = busy_q;

endmodule

// File: tb/tb_btn_press_encoder.sv
// tb/tb_btn_press_encoder.sv - self-checking bench for btn_press_encoder

module tb_btn_press_encoder;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] btn_raw;

    btn_press_encoder_if bus ();

    btn_press_encoder #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (20),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_raw),
        .evt     (bus)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a press is accepted once the same non-empty key set
    // has been seen for D+1 consecutive samples while armed; re-arming needs
    // D+1 consecutive all-released samples.
    logic [2:0] m_sync0, m_sync1;
    logic [2:0] m_last;
    int         m_run;
    bit         m_armed;
    logic       m_valid;
    logic [1:0] m_code;
    logic       m_ovf;
    logic       m_busy;

    function automatic logic [1:0] enc(input logic [2:0] keys);
        if ($countones(keys) != 1) return 2'b11;
        for (int i = 0; i < 3; i++)
            if (keys[i]) return 2'(i);
        return 2'b11;
    endfunction

    task automatic model_edge();
        logic [2:0] p;
        bit         emit;
        if (!reset) begin
            m_sync0 = 3'b111;
            m_sync1 = 3'b111;
            m_armed = 1'b1;
            m_run   = 0;
            m_last  = 3'b000;
            m_valid = 1'b0;
            m_code  = 2'b00;
            m_ovf   = 1'b0;
            m_busy  = 1'b0;
        end else begin
            p       = ~m_sync1;
            m_sync1 = m_sync0;
            m_sync0 = btn_raw;
            if (m_run > 0 && p == m_last) m_run++;
            else m_run = 1;
            m_last = p;
            emit = 1'b0;
            if (m_armed && p != 3'b000 && m_run == D + 1) begin
                emit    = 1'b1;
                m_armed = 1'b0;
            end else if (!m_armed && p == 3'b000 && m_run == D + 1) begin
                m_armed = 1'b1;
            end
            if (emit) begin
                if (!m_valid || bus.press_ack) begin
                    m_valid = 1'b1;
                    m_code  = enc(p);
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (bus.press_ack) begin
                m_valid = 1'b0;
            end
            m_busy = !(m_armed && p == 3'b000);
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] raw, input logic ack, input logic rstn);
        btn_raw       = raw;
        bus.press_ack = ack;
        reset         = rstn;
        @(posedge clock);
        model_edge();
        #1;
        check("valid",    {1'b0, bus.press_valid},    {1'b0, m_valid});
        check("code",     bus.press_code,             m_code);
        check("overflow", {1'b0, bus.press_overflow}, {1'b0, m_ovf});
        check("busy",     {1'b0, bus.busy},           {1'b0, m_busy});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b111, 1'b0, 1'b1);
    endtask

    initial begin
        logic [2:0] raw;
        int         len;

        // Reset held with keys released
        for (int i = 0; i < 3; i++) step(3'b111, 1'b0, 1'b0);
        check("rst_valid", {1'b0, bus.press_valid},    2'b00);
        check("rst_code",  bus.press_code,             2'b00);
        check("rst_ovf",   {1'b0, bus.press_overflow}, 2'b00);
        check("rst_busy",  {1'b0, bus.busy},           2'b00);
        idle(3);
        check("post_rst_valid", {1'b0, bus.press_valid}, 2'b00);
        check("post_rst_busy",  {1'b0, bus.busy},        2'b00);

        // Clean single press of key 0
        for (int k = 1; k <= 20; k++) begin
            step(3'b110, 1'b0, 1'b1);
            if (k == 6) check("lat_e6_valid", {1'b0, bus.press_valid}, 2'b00);
            if (k == 7) begin
                check("lat_e7_valid", {1'b0, bus.press_valid}, 2'b01);
                check("lat_e7_code",  bus.press_code,          2'b00);
            end
        end
        idle(8);
        check("release_busy", {1'b0, bus.busy}, 2'b00);
        step(3'b111, 1'b1, 1'b1);
        check("ack1_valid", {1'b0, bus.press_valid}, 2'b00);

        // Bounce on key 1, then stable
        for (int s = 0; s < 5; s++)
            for (int c = 0; c < 2; c++) begin
                step((s % 2 == 1) ? 3'b101 : 3'b111, 1'b0, 1'b1);
                check("bounce_no_event", {1'b0, bus.press_valid}, 2'b00);
            end
        for (int k = 1; k <= 12; k++) begin
            step(3'b101, 1'b0, 1'b1);
            if (k == 6) check("bounce_e6_valid", {1'b0, bus.press_valid}, 2'b00);
            if (k == 7) begin
                check("bounce_e7_valid", {1'b0, bus.press_valid}, 2'b01);
                check("bounce_e7_code",  bus.press_code,          2'b01);
            end
        end
        idle(10);
        step(3'b111, 1'b1, 1'b1);

        // Chord of keys 0 and 2, then a single-cycle ack
        for (int k = 0; k < 12; k++) step(3'b010, 1'b0, 1'b1);
        check("chord_code", bus.press_code, 2'b11);
        step(3'b010, 1'b1, 1'b1);
        check("chord_ack_valid", {1'b0, bus.press_valid}, 2'b00);
        idle(10);

        // Overflow: two presses without ack
        for (int k = 0; k < 12; k++) step(3'b011, 1'b0, 1'b1);
        idle(10);
        for (int k = 0; k < 12; k++) step(3'b110, 1'b0, 1'b1);
        idle(10);
        check("ovf_code", bus.press_code,             2'b10);
        check("ovf_flag", {1'b0, bus.press_overflow}, 2'b01);
        step(3'b111, 1'b1, 1'b1);
        check("ovf_ack_valid", {1'b0, bus.press_valid},    2'b00);
        check("ovf_sticky",    {1'b0, bus.press_overflow}, 2'b01);

        // Ack colliding with the emit of a second press
        for (int i = 0; i < 2; i++) step(3'b111, 1'b0, 1'b0);
        idle(3);
        for (int k = 0; k < 12; k++) step(3'b011, 1'b0, 1'b1);
        idle(10);
        for (int k = 1; k <= 10; k++) step(3'b110, (k == 7), 1'b1);
        check("coll_valid", {1'b0, bus.press_valid},    2'b01);
        check("coll_code",  bus.press_code,             2'b00);
        check("coll_ovf",   {1'b0, bus.press_overflow}, 2'b00);
        idle(10);
        step(3'b111, 1'b1, 1'b1);

        // Reset in the middle of debouncing a press
        for (int k = 0; k < 4; k++) step(3'b101, 1'b0, 1'b1);
        step(3'b111, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(3'b111, 1'b0, 1'b1);
            check("midrst_no_event", {1'b0, bus.press_valid}, 2'b00);
        end
        check("midrst_busy", {1'b0, bus.busy}, 2'b00);

        // Randomised key activity, acks and occasional resets
        for (int n = 0; n < 150; n++) begin
            raw = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) raw = 3'b111;
            len = int'($urandom_range(1, 12));
            for (int k = 0; k < len; k++)
                step(raw, ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
